// File: rtl/dmglcd_pkg.sv
// dmglcd_pkg: shared types and constants for the DMG LCD capture block.
//   cap_state_t          - line/frame recovery state
//   ERR_*                - bit positions inside the sticky err vector
//   DMG_WIDTH/DMG_HEIGHT - native DMG screen geometry (default parameters)
package dmglcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEAD = 2'd1,
    PIX  = 2'd2,
    WAIT = 2'd3
  } cap_state_t;

  localparam int ERR_OVR  = 0;
  localparam int ERR_UNR  = 1;
  localparam int ERR_YOVF = 2;
  localparam int ERR_POL  = 3;

  localparam int DMG_WIDTH  = 160;
  localparam int DMG_HEIGHT = 144;

endpackage

// File: rtl/dmglcd_sync.sv
// dmglcd_sync: STAGES-deep single-bit synchronizer followed by one edge
// register. rise_o/fall_o are registered one-cycle pulses, and q_o is the
// edge register itself, so a level read alongside a pulse already shows the
// post-edge value.
//   clk_i, reset_i - capture clock, synchronous active-high reset
//   d_i            - asynchronous pin
//   q_o            - synchronized level, aligned with rise_o/fall_o
//   rise_o, fall_o - one-cycle edge pulses
module dmglcd_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign q_o    = prev_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/dmglcd_capture.sv
// dmglcd_capture: oversampling receiver for the DMG LCD pin bus. Recovers
// line/frame structure and emits one framebuffer write per pixel.
//   clk, reset          - capture clock (>= 4x lcd_clk toggle rate), sync reset
//   lcd_*               - asynchronous LCD pins
//   err_clr             - one-cycle pulse clearing the sticky err flags
//   wr_en/x/y/addr/data - framebuffer write port
//   frame_start/done    - one-cycle frame strobes
//   line_cnt            - current line index (y)
//   err                 - sticky {pol, y overflow, underrun, overrun}
//   state_dbg           - current capture state, for observation only
// Optional: define DMGLCD_CAP_POLCHK_EN to build the line-polarity check
// that drives err[3]; otherwise err[3] stays 0.
//
// Write port handshake: wr_en is a valid-only strobe with no ready; the RAM
// must accept every write. wr_x/wr_y/wr_addr/wr_data are valid while wr_en=1
// and hold their last values otherwise.
module dmglcd_capture
  import dmglcd_pkg::*;
#(
  parameter int WIDTH       = DMG_WIDTH,
  parameter int HEIGHT      = DMG_HEIGHT,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  lcd_d,
  input  logic        lcd_clk,
  input  logic        lcd_hsync,
  input  logic        lcd_vsync,
  input  logic        lcd_latch,
  input  logic        lcd_pol,
  input  logic        err_clr,
  output logic        wr_en,
  output logic [7:0]  wr_x,
  output logic [7:0]  wr_y,
  output logic [14:0] wr_addr,
  output logic [1:0]  wr_data,
  output logic        frame_start,
  output logic        frame_done,
  output logic [7:0]  line_cnt,
  output logic [3:0]  err,
  output cap_state_t  state_dbg
);

  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

  // Pin synchronizers
  logic clk_fall, hs_rise, hs_lvl, vs_lvl, latch_rise, latch_fall;
  logic unused_clk_lvl, unused_clk_rise, unused_hs_fall;
  logic unused_vs_rise, unused_vs_fall, unused_latch_lvl;

  dmglcd_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk_i(clk), .reset_i(reset), .d_i(lcd_clk),
    .q_o(unused_clk_lvl), .rise_o(unused_clk_rise), .fall_o(clk_fall));
  dmglcd_sync #(.STAGES(SYNC_STAGES)) u_sync_hs (
    .clk_i(clk), .reset_i(reset), .d_i(lcd_hsync),
    .q_o(hs_lvl), .rise_o(hs_rise), .fall_o(unused_hs_fall));
  dmglcd_sync #(.STAGES(SYNC_STAGES)) u_sync_vs (
    .clk_i(clk), .reset_i(reset), .d_i(lcd_vsync),
    .q_o(vs_lvl), .rise_o(unused_vs_rise), .fall_o(unused_vs_fall));
  dmglcd_sync #(.STAGES(SYNC_STAGES)) u_sync_latch (
    .clk_i(clk), .reset_i(reset), .d_i(lcd_latch),
    .q_o(unused_latch_lvl), .rise_o(latch_rise), .fall_o(latch_fall));

  // Data pins: plain synchronizer, read when the registered clk_fall fires.
  // The DMG holds data through the whole low phase, so the extra edge-register
  // cycle on clk_fall still lands inside the valid window.
  logic [SYNC_STAGES-1:0][1:0] d_sync_q;

  always_ff @(posedge clk) begin
    if (reset) d_sync_q <= '0;
    else       d_sync_q <= {d_sync_q[SYNC_STAGES-2:0], lcd_d};
  end

  // Capture state
  cap_state_t  state_q, state_d;
  logic [7:0]  x_q, x_d, y_q, y_d;
  logic [14:0] base_q, base_d;
  logic        full_q, full_d;
  logic [3:0]  err_q, err_d, fsm_err, pol_set;
  logic        fs_q, fs_d, fd_q, fd_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_x_q, wr_x_d, wr_y_q, wr_y_d;
  logic [14:0] wr_addr_q, wr_addr_d;
  logic [1:0]  wr_data_q, wr_data_d;
  logic        line_evt, start_frame;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    base_d      = base_q;
    full_d      = full_q;
    fsm_err     = '0;
    fs_d        = 1'b0;
    fd_d        = 1'b0;
    wr_en_d     = 1'b0;
    wr_x_d      = wr_x_q;
    wr_y_d      = wr_y_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    line_evt    = 1'b0;
    start_frame = 1'b0;

    case (state_q)
      IDLE: start_frame = hs_rise & vs_lvl;
      LEAD: begin
        // The first falling edge after hsync is the line-start clock.
        if (hs_rise && vs_lvl) start_frame = 1'b1;
        else if (clk_fall) begin
          state_d = PIX;
          x_d     = '0;
        end
      end
      PIX: begin
        if (latch_rise || hs_rise) begin
          // Line ended early; the same event is then handled as in WAIT.
          fsm_err[ERR_UNR] = 1'b1;
          state_d          = WAIT;
          full_d           = 1'b0;
          line_evt         = 1'b1;
        end else if (clk_fall) begin
          wr_en_d   = 1'b1;
          wr_x_d    = x_q;
          wr_y_d    = y_q;
          wr_addr_d = base_q + 15'(x_q);
          wr_data_d = d_sync_q[SYNC_STAGES-1];
          if (x_q == X_LAST) begin
            state_d = WAIT;
            full_d  = 1'b1;
          end else begin
            x_d = x_q + 8'd1;
          end
        end
      end
      WAIT:    line_evt = 1'b1;
      default: state_d = IDLE;
    endcase

    if (line_evt) begin
      if (latch_rise && y_q == Y_LAST) begin
        fd_d    = 1'b1;
        state_d = IDLE;
      end else if (hs_rise && vs_lvl) begin
        start_frame = 1'b1;
      end else if (hs_rise) begin
        if (y_q == Y_LAST) begin
          fsm_err[ERR_YOVF] = 1'b1;
          state_d           = IDLE;
        end else begin
          y_d     = y_q + 8'd1;
          base_d  = base_q + 15'(WIDTH);
          full_d  = 1'b0;
          state_d = LEAD;
        end
      end else if (latch_rise) begin
        full_d = 1'b0;
      end else if (clk_fall && full_q && !hs_lvl && state_q == WAIT) begin
        // Extra pixel clock after a complete line; never written.
        fsm_err[ERR_OVR] = 1'b1;
      end
    end

    if (start_frame) begin
      y_d     = '0;
      base_d  = '0;
      full_d  = 1'b0;
      fs_d    = 1'b1;
      state_d = LEAD;
    end
  end

`ifdef DMGLCD_CAP_POLCHK_EN
  // Polarity must alternate line to line; the first line of a frame only
  // seeds the reference value.
  logic pol_lvl, pol_prev_q, pol_valid_q, pol_err;
  logic unused_pol_rise, unused_pol_fall;

  dmglcd_sync #(.STAGES(SYNC_STAGES)) u_sync_pol (
    .clk_i(clk), .reset_i(reset), .d_i(lcd_pol),
    .q_o(pol_lvl), .rise_o(unused_pol_rise), .fall_o(unused_pol_fall));

  always_ff @(posedge clk) begin
    if (reset) begin
      pol_prev_q  <= 1'b0;
      pol_valid_q <= 1'b0;
    end else if (fs_q) begin
      pol_valid_q <= 1'b0;
    end else if (latch_fall) begin
      pol_prev_q  <= pol_lvl;
      pol_valid_q <= 1'b1;
    end
  end

  assign pol_err = latch_fall & pol_valid_q & ~fs_q & (pol_lvl == pol_prev_q);
`else
  logic pol_err;
  logic unused_pol;
  assign pol_err    = 1'b0;
  assign unused_pol = lcd_pol ^ latch_fall;
`endif

  always_comb begin
    pol_set          = '0;
    pol_set[ERR_POL] = pol_err;
  end

  // A new error in the same cycle as err_clr survives.
  assign err_d = (err_q & ~{4{err_clr}}) | fsm_err | pol_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      base_q    <= '0;
      full_q    <= 1'b0;
      err_q     <= '0;
      fs_q      <= 1'b0;
      fd_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_x_q    <= '0;
      wr_y_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      base_q    <= base_d;
      full_q    <= full_d;
      err_q     <= err_d;
      fs_q      <= fs_d;
      fd_q      <= fd_d;
      wr_en_q   <= wr_en_d;
      wr_x_q    <= wr_x_d;
      wr_y_q    <= wr_y_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_x        = wr_x_q;
  assign wr_y        = wr_y_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;
  assign line_cnt    = y_q;
  assign err         = err_q;
  assign state_dbg   = state_q;

endmodule

// File: doc/dmglcd_capture.md
Name: dmglcd_capture

Overview:
- Receiver for the DMG LCD pin bus (lcd_d, lcd_clk, lcd_hsync, lcd_vsync, lcd_latch, lcd_pol), the same bus our LCD driver drives and the real DMG drives.
- Oversamples the bus in its own clock domain and recovers line and frame structure.
- Emits one framebuffer write per pixel (x, y, linear address, 2-bit value), plus frame strobes and sticky protocol-error flags.
- Sits between the LCD pins and a dual-port framebuffer RAM.

Parameters:
- WIDTH, 160, pixels per line.
- HEIGHT, 144, lines per frame.
- SYNC_STAGES, 2, flip-flop stages in each pin synchronizer (legal range 2..4).

Ports:
- clk  in  1  capture clock; frequency must be at least 4x the lcd_clk toggle rate (clk16m against the 4 MHz pixel clock).
- reset  in  1  synchronous, active-high.
- lcd_d  in  2  pixel data pins.
- lcd_clk  in  1  pixel clock pin.
- lcd_hsync  in  1  line-start pin.
- lcd_vsync  in  1  frame-start pin.
- lcd_latch  in  1  line-latch pin.
- lcd_pol  in  1  polarity pin.
- err_clr  in  1  single-cycle pulse; clears all sticky error flags.
- wr_en  out  1  one-cycle framebuffer write strobe.
- wr_x  out  8  pixel column.
- wr_y  out  8  pixel row.
- wr_addr  out  15  wr_y*WIDTH+wr_x.
- wr_data  out  2  pixel value.
- frame_start  out  1  one-cycle pulse when line 0 begins.
- frame_done  out  1  one-cycle pulse when line HEIGHT-1 is complete.
- line_cnt  out  8  current line index.
- err  out  4  sticky flags: [0] overrun, [1] underrun, [2] y overflow, [3] pol (reserved, 0 unless the optional feature is compiled in).

Behaviour:
- Synchronizers and edges:
  - Every lcd_* pin passes through SYNC_STAGES flip-flops, then one edge-detect register.
  - Edges are detected on the synchronized signals only.
  - lcd_d is sampled from its synchronizer output in the same cycle the lcd_clk falling edge is detected.
- Reset values: all outputs 0; state IDLE; x=0, y=0; synchronizer and edge registers cleared to 0.
- Reset mid-line: discards the partial line with no write and no error; capture resumes at the next vsync line.
- State machine:
  - IDLE: on hsync rise with vsync=1 -> set y=0, pulse frame_start, go LEAD. All other activity is ignored.
  - LEAD: the first lcd_clk falling edge after the hsync rise is the line-start clock and is never written; go PIX with x=0.
  - PIX: each lcd_clk falling edge writes pixel x, then x++.
    - After the write with x=WIDTH-1 -> go WAIT.
    - A latch rise or hsync rise while x<WIDTH: set err[1], go WAIT, and treat that event as the WAIT transition in the same cycle.
  - WAIT:
    - lcd_clk falling edges are ignored; a falling edge arriving while hsync=1 before LEAD is not counted.
    - latch rise with y=HEIGHT-1 -> pulse frame_done, go IDLE.
    - hsync rise with vsync=1 -> restart the frame: set y=0, pulse frame_start, go LEAD.
    - hsync rise with vsync=0 -> y++, go LEAD. If the new y would reach HEIGHT, set err[2], go IDLE, and perform no write.
- Overrun rule: err[0] is set by a falling edge in WAIT that follows a completed line (x reached WIDTH) before the next latch or hsync rise. No write is issued for it.
- Write port:
  - wr_en is a single cycle.
  - wr_x, wr_y, wr_addr and wr_data are registered and valid while wr_en=1; they hold their values otherwise.
  - Latency from the lcd_clk falling edge at the pin to wr_en is SYNC_STAGES+2 clk cycles.
  - wr_addr is computed with a registered multiply-free accumulator: a row base adds WIDTH per line, then x is added.
- Simultaneous events: err_clr in the same cycle as a new error leaves the new flag set (set wins).
- line_cnt = y; it is updated on the cycle of the transition.

Optional Feature:
- Macro: DMGLCD_CAP_POLCHK_EN.
- Defined:
  - Record the synchronized lcd_pol value at each latch fall.
  - For consecutive lines within a frame, pol must differ from the previous recorded value; if not, set err[3].
  - The first line of a frame is exempt.
- Undefined: err[3] is tied to 0 and no polarity logic is built.

Decomposition:
- Package dmglcd_pkg holds:
  - enum cap_state_t {IDLE, LEAD, PIX, WAIT};
  - localparams for the err bit indices ERR_OVR, ERR_UNR, ERR_YOVF, ERR_POL;
  - the DMG default geometry constants (160, 144).
- One sub-module, dmglcd_sync: an N-stage synchronizer with registered rise/fall outputs, instantiated once per control pin. lcd_d uses the plain synchronizer path only.

Test Plan:
- Nominal frame: drive 144 lines of 160 pixels (value = (x+y)&3), vsync on line 0 -> exactly 23040 writes, wr_addr 0..23039 in order, one frame_start and one frame_done, err=0.
- Short line: on line 5, assert latch after 100 pixels -> err[1]=1; line 6 writes start at wr_addr 960; 100 writes for line 5.
- Extra clocks: on line 7, issue 163 falling edges -> 160 writes, err[0]=1; err_clr pulse -> err=0.
- Mid-frame restart: vsync with hsync at line 50 -> frame_start pulse, next write has wr_y=0, wr_x=0, and no frame_done.
- Latency and reset: with SYNC_STAGES=3, wr_en occurs 5 cycles after the pin edge; reset asserted mid-line 20 -> outputs 0, state IDLE, and no write until the next vsync.
- DMGLCD_CAP_POLCHK_EN defined: hold pol constant across lines 3 and 4 -> err[3]=1. Undefined: same stimulus -> err[3]=0.
